// File: rtl/ibuf_credit_sender_pkg.sv
// Shared widths and helpers for the decode-side instruction-buffer credit sender.
package ibuf_credit_sender_pkg;

   function automatic int log2up(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int credits);
      return $clog2(credits + 1);
   endfunction

   localparam int ISSUE_WIDTH_DEF = 4;
   localparam int NUM_WARPS_DEF   = 16;
   localparam int ISW_W           = log2up(ISSUE_WIDTH_DEF);
   localparam int NW_W            = log2up(NUM_WARPS_DEF);

   // Issue slot of a warp is wid modulo ISSUE_WIDTH; a single slot is always slot 0.
   function automatic int unsigned wid_to_isw(input int unsigned wid,
                                              input int unsigned issue_width);
      return (issue_width > 1) ? (wid & (issue_width - 1)) : 0;
   endfunction

endpackage

// File: rtl/ibuf_credit_sender_counter.sv
// Per-slot saturating credit counters: one inc/dec counter per issue slot.
module ibuf_credit_counter
   import ibuf_credit_sender_pkg::*;
#(
   parameter int ISSUE_WIDTH = 4,
   parameter int CREDITS     = 4,
   parameter int CNT_W       = cnt_width(CREDITS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [ISSUE_WIDTH-1:0]       inc,
   input  logic [ISSUE_WIDTH-1:0]       dec,
   output logic [ISSUE_WIDTH*CNT_W-1:0] count,
   output logic [ISSUE_WIDTH-1:0]       zero,
   output logic [ISSUE_WIDTH-1:0]       overflow
);

   for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_slot
      logic [CNT_W-1:0] cnt;

      // NOTE: sequential state uses non-blocking assignments so every counter
      // samples the same pre-edge values.
      always_ff @(posedge clk) begin
         if (!reset) begin
            cnt <= CNT_W'(CREDITS);
         end else if (inc[i] && !dec[i]) begin
            if (cnt != CNT_W'(CREDITS))
               cnt <= cnt + CNT_W'(1);
         end else if (dec[i] && !inc[i]) begin
            cnt <= cnt - CNT_W'(1);
         end
      end

      assign count[i*CNT_W +: CNT_W] = cnt;
      assign zero[i]                 = (cnt == '0);
      assign overflow[i]             = inc[i] && !dec[i] && (cnt == CNT_W'(CREDITS));
   end

endmodule

// File: rtl/ibuf_credit_sender.sv
// Registers decoded instructions and presents them to their issue slot only
// when that slot's buffer has a credit; returns credits on ibuf_pop.
module ibuf_credit_sender
   import ibuf_credit_sender_pkg::*;
#(
   parameter  int ISSUE_WIDTH = 4,
   parameter  int NUM_WARPS   = 16,
   parameter  int CREDITS     = 4,
   parameter  int DATAW       = 128,
   localparam int NW_BITS     = log2up(NUM_WARPS),
   localparam int ISW_BITS    = log2up(ISSUE_WIDTH),
   localparam int CNT_W       = cnt_width(CREDITS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [NW_BITS-1:0]           in_wid,
   input  logic [DATAW-1:0]             in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [NW_BITS-1:0]           out_wid,
   output logic [DATAW-1:0]             out_data,
   input  logic                         out_ready,
   input  logic [ISSUE_WIDTH-1:0]       ibuf_pop,
   output logic [ISSUE_WIDTH-1:0]       slot_full,
   output logic [ISSUE_WIDTH*CNT_W-1:0] credit_cnt,
   output logic                         credit_err
);

   logic                   reg_valid;
   logic [NW_BITS-1:0]     reg_wid;
   logic [DATAW-1:0]       reg_data;
   logic [ISW_BITS-1:0]    reg_isw;
   logic                   fire;
   logic [ISSUE_WIDTH-1:0] dec;
   logic [ISSUE_WIDTH-1:0] zero;
   logic [ISSUE_WIDTH-1:0] overflow;

   assign reg_isw   = ISW_BITS'(wid_to_isw(32'(reg_wid), ISSUE_WIDTH));
   assign out_valid = reg_valid && !zero[reg_isw];
   assign fire      = out_valid && out_ready;
   assign in_ready  = !reg_valid || fire;
   assign out_wid   = reg_wid;
   assign out_data  = reg_data;
   assign slot_full = zero;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      dec = '0;
      if (fire)
         dec[reg_isw] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset)
         reg_valid <= 1'b0;
      else if (in_valid && in_ready)
         reg_valid <= 1'b1;
      else if (fire)
         reg_valid <= 1'b0;
   end

   // NOTE: the payload is qualified by reg_valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         reg_wid  <= in_wid;
         reg_data <= in_data;
      end
   end

   // Credits guarantee buffer space, so a refused presentation is an error too.
   always_ff @(posedge clk) begin
      if (!reset)
         credit_err <= 1'b0;
      else if ((|overflow) || (out_valid && !out_ready))
         credit_err <= 1'b1;
   end

   ibuf_credit_counter #(
      .ISSUE_WIDTH (ISSUE_WIDTH),
      .CREDITS     (CREDITS),
      .CNT_W       (CNT_W)
   ) u_credit_counter (
      .clk      (clk),
      .reset    (reset),
      .inc      (ibuf_pop),
      .dec      (dec),
      .count    (credit_cnt),
      .zero     (zero),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_ibuf_credit_sender.sv
// Directed bench for ibuf_credit_sender: streaming, credit exhaustion,
// simultaneous pop/fire, overflow, refused presentation and mid-run reset.
module tb_ibuf_credit_sender;

   localparam int CNT_W = 3;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [3:0]   in_wid;
   logic [127:0] in_data;
   logic         in_ready;
   logic         out_valid;
   logic [3:0]   out_wid;
   logic [127:0] out_data;
   logic         out_ready;
   logic [3:0]   ibuf_pop;
   logic [3:0]   slot_full;
   logic [11:0]  credit_cnt;
   logic         credit_err;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   ibuf_credit_sender dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_wid     (in_wid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_wid    (out_wid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .ibuf_pop   (ibuf_pop),
      .slot_full  (slot_full),
      .credit_cnt (credit_cnt),
      .credit_err (credit_err)
   );

   task automatic check(input string tag, input logic [127:0] actual,
                        input logic [127:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int cred(input int i);
      return int'(credit_cnt[i*CNT_W +: CNT_W]);
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_wid    = '0;
      in_data   = '0;
      out_ready = 1'b1;
      ibuf_pop  = '0;
      tick();
      tick();
      reset = 1'b1;
      tick();

      // Reset state
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_credits", 128'(credit_cnt), 128'(12'h924));
      check("rst_slot_full", 128'(slot_full), 128'(0));
      check("rst_credit_err", 128'(credit_err), 128'(0));

      // Streaming wid 0..3 back-to-back
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_wid   = 4'(k);
         in_data  = 128'(100 + k);
         check($sformatf("stream_in_ready_%0d", k), 128'(in_ready), 128'(1));
         tick();
         check($sformatf("stream_valid_%0d", k), 128'(out_valid), 128'(1));
         check($sformatf("stream_wid_%0d", k), 128'(out_wid), 128'(k));
         check($sformatf("stream_data_%0d", k), out_data, 128'(100 + k));
      end
      in_valid = 1'b0;
      tick();
      check("stream_drained", 128'(out_valid), 128'(0));
      check("stream_credits", 128'(credit_cnt), 128'(12'h6DB));

      // Credit exhaustion on slot 0 from a fresh reset
      do_reset();
      tick();
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_wid   = 4'd4;
         in_data  = 128'(200 + k);
         check($sformatf("exh_in_ready_%0d", k), 128'(in_ready), 128'(1));
         tick();
      end
      in_valid = 1'b0;
      check("exh_out_valid", 128'(out_valid), 128'(0));
      check("exh_in_ready", 128'(in_ready), 128'(0));
      check("exh_credit0", 128'(cred(0)), 128'(0));
      check("exh_slot_full", 128'(slot_full), 128'(4'b0001));
      tick();
      check("exh_hold_valid", 128'(out_valid), 128'(0));
      check("exh_hold_data", out_data, 128'(204));
      ibuf_pop = 4'b0001;
      check("exh_pop_same_cycle", 128'(out_valid), 128'(0));
      tick();
      ibuf_pop = 4'b0000;
      check("exh_after_pop_valid", 128'(out_valid), 128'(1));
      check("exh_after_pop_data", out_data, 128'(204));
      check("exh_after_pop_credit0", 128'(cred(0)), 128'(1));
      tick();
      check("exh_final_valid", 128'(out_valid), 128'(0));
      check("exh_final_in_ready", 128'(in_ready), 128'(1));
      check("exh_final_credit0", 128'(cred(0)), 128'(0));
      check("exh_no_err", 128'(credit_err), 128'(0));

      // Fire to slot 2 in the same cycle as ibuf_pop[2]
      in_valid = 1'b1;
      in_wid   = 4'd2;
      in_data  = 128'(300);
      tick();
      in_wid  = 4'd6;
      in_data = 128'(301);
      tick();
      in_valid = 1'b0;
      check("sim_credit2_before", 128'(cred(2)), 128'(3));
      check("sim_fire_valid", 128'(out_valid), 128'(1));
      ibuf_pop = 4'b0100;
      tick();
      ibuf_pop = 4'b0000;
      check("sim_credit2_after", 128'(cred(2)), 128'(3));
      check("sim_no_err", 128'(credit_err), 128'(0));

      // Overflow on slot 1 at full credit
      check("ovf_credit1_before", 128'(cred(1)), 128'(4));
      ibuf_pop = 4'b0010;
      tick();
      ibuf_pop = 4'b0000;
      check("ovf_credit1", 128'(cred(1)), 128'(4));
      check("ovf_err", 128'(credit_err), 128'(1));
      tick();
      tick();
      check("ovf_err_sticky", 128'(credit_err), 128'(1));

      // Refused presentation is a protocol violation
      do_reset();
      tick();
      check("pv_err_cleared", 128'(credit_err), 128'(0));
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_wid    = 4'd1;
      in_data   = 128'(400);
      tick();
      in_valid = 1'b0;
      check("pv_out_valid", 128'(out_valid), 128'(1));
      check("pv_in_ready", 128'(in_ready), 128'(0));
      tick();
      check("pv_err", 128'(credit_err), 128'(1));
      check("pv_held_data", out_data, 128'(400));
      check("pv_credit1_held", 128'(cred(1)), 128'(4));
      out_ready = 1'b1;
      tick();
      check("pv_fired_credit1", 128'(cred(1)), 128'(3));
      check("pv_drained", 128'(out_valid), 128'(0));

      // Mid-operation reset with a stalled instruction and pops during reset
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_wid   = 4'd8;
         in_data  = 128'(500 + k);
         tick();
      end
      in_valid = 1'b0;
      check("mid_pre_credit0", 128'(cred(0)), 128'(0));
      check("mid_pre_in_ready", 128'(in_ready), 128'(0));
      reset    = 1'b0;
      ibuf_pop = 4'b1111;
      tick();
      reset    = 1'b1;
      ibuf_pop = 4'b0000;
      check("mid_out_valid", 128'(out_valid), 128'(0));
      check("mid_in_ready", 128'(in_ready), 128'(1));
      check("mid_credits", 128'(credit_cnt), 128'(12'h924));
      check("mid_slot_full", 128'(slot_full), 128'(0));
      check("mid_credit_err", 128'(credit_err), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
